dsi_video_packetizer: RTL and testbench

- Transmit-side counterpart of the RGB extractor: takes the video stream (r/g/b pixels plus hsync/vsync) and emits a MIPI DSI video-mode packet byte stream.
- Emits VSS/HSS short packets on sync edges and one RGB888 long packet (header, payload, CRC) per active line.
- Sits between the pixel source and the lane/serializer layer; the output byte stream uses a valid/ready handshake.

---
 rtl/dsi_video_packetizer.sv | 216 +++++++++++++++++++++
 tb/tb_dsi_video_packetizer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_video_packetizer.sv
`default_nettype none
//==============================================================================
// Module   : dsi_video_packetizer
// Desc     : Converts an r/g/b pixel stream with hsync/vsync into a MIPI DSI
//            video-mode byte stream: VSS/HSS short packets on sync rising
//            edges, one RGB888 long packet (header, payload, CRC) per line.
// Revision : 1.0 - initial release
//==============================================================================
module dsi_video_packetizer #(
  parameter int         H_ACTIVE  = 640,
  parameter logic [1:0] VC        = 2'd0,
  parameter logic [5:0] DT_VSS    = 6'h01,
  parameter logic [5:0] DT_HSS    = 6'h21,
  parameter logic [5:0] DT_RGB888 = 6'h3E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       sync_drop
);

  localparam logic [15:0] C_WC   = 16'(H_ACTIVE * 3);
  localparam logic [14:0] C_NPIX = 15'(H_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC} state_t;

  // DSI header ECC: 6-bit Hamming over {WC, DI}, top two bits zero
  function automatic logic [7:0] f_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Byte-wide update of the reflected x^16+x^12+x^5+1 CRC (LSB-first)
  function automatic logic [15:0] f_crc(input logic [15:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = d ^ c[7:0];
    x = x ^ {x[3:0], 4'h0};
    return ({x, 8'h00} | {8'h00, c[15:8]}) ^ {12'h000, x[7:4]} ^ {5'b00000, x, 3'b000};
  endfunction

  state_t      r_state;
  logic        r_vs_s, r_vs_d, r_hs_s, r_hs_d;
  logic        r_vss_pend, r_hss_pend, r_sync_drop;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid, r_tx_sop, r_tx_eop;
  logic        r_pix_ready, r_pix_full, r_long;
  logic [23:0] r_pix, r_hdr_sh;
  logic [15:0] r_gb, r_crc;
  logic [1:0]  r_phase, r_idx;
  logic [14:0] r_pix_cnt, r_req_cnt;

  logic        w_vs_edge, w_hs_edge, w_slot, w_boundary;
  logic        w_sel_vss, w_sel_hss, w_long_start, w_pay_load;
  logic        w_pix_hs, w_take, w_full_nxt;
  logic [14:0] w_req_nxt;
  logic [7:0]  w_di, w_ecc;
  logic [15:0] w_wc;

  assign w_vs_edge    = r_vs_s & ~r_vs_d;
  assign w_hs_edge    = r_hs_s & ~r_hs_d;
  // Output register can take a new byte this cycle
  assign w_slot       = ~r_tx_valid | tx_ready;
  // Idle, or the last byte of a packet is leaving: pick the next packet now
  assign w_boundary   = (r_state == S_IDLE) | (r_tx_valid & tx_ready & r_tx_eop);
  assign w_sel_vss    = w_boundary & r_vss_pend;
  assign w_sel_hss    = w_boundary & ~r_vss_pend & r_hss_pend;
  assign w_long_start = w_boundary & ~r_vss_pend & ~r_hss_pend & pix_valid;
  // Only a long packet reaches HDR with all four header bytes presented
  assign w_pay_load   = w_slot & ~w_boundary &
                        ((r_state == S_PAYLOAD) | ((r_state == S_HDR) & (r_idx == 2'd3)));
  assign w_pix_hs     = pix_valid & r_pix_ready;
  assign w_take       = w_pay_load & (r_phase == 2'd0) & (r_pix_cnt != C_NPIX) & r_pix_full;
  assign w_full_nxt   = (r_pix_full & ~w_take) | w_pix_hs;
  assign w_req_nxt    = w_long_start ? 15'd0 : (r_req_cnt + 15'(w_pix_hs));

  assign w_di  = {VC, w_sel_vss ? DT_VSS : (w_sel_hss ? DT_HSS : DT_RGB888)};
  assign w_wc  = (w_sel_vss | w_sel_hss) ? 16'h0000 : C_WC;
  assign w_ecc = f_ecc({w_wc, w_di});

  // Sync edge detection and pending-request bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_s      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_hs_s      <= 1'b0;
      r_hs_d      <= 1'b0;
      r_vss_pend  <= 1'b0;
      r_hss_pend  <= 1'b0;
      r_sync_drop <= 1'b0;
    end else begin
      r_vs_s      <= vsync;
      r_vs_d      <= r_vs_s;
      r_hs_s      <= hsync;
      r_hs_d      <= r_hs_s;
      r_vss_pend  <= (r_vss_pend & ~w_sel_vss) | w_vs_edge;
      r_hss_pend  <= (r_hss_pend & ~w_sel_hss) | w_hs_edge;
      r_sync_drop <= (w_vs_edge & r_vss_pend & ~w_sel_vss) |
                     (w_hs_edge & r_hss_pend & ~w_sel_hss);
    end
  end

  // One-pixel prefetch buffer so the payload streams without bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix       <= 24'h0;
      r_pix_full  <= 1'b0;
      r_req_cnt   <= 15'd0;
      r_pix_ready <= 1'b0;
    end else begin
      if (w_pix_hs) r_pix <= {r, g, b};
      r_pix_full  <= w_full_nxt;
      r_req_cnt   <= w_req_nxt;
      r_pix_ready <= (w_long_start | r_long) & ~w_full_nxt & (w_req_nxt < C_NPIX);
    end
  end

  // Packet sequencer with registered byte-stream outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_hdr_sh   <= 24'h0;
      r_idx      <= 2'd0;
      r_long     <= 1'b0;
      r_crc      <= 16'h0000;
      r_gb       <= 16'h0000;
      r_phase    <= 2'd0;
      r_pix_cnt  <= 15'd0;
    end else if (w_boundary) begin
      r_state    <= S_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_long     <= 1'b0;
      if (w_sel_vss | w_sel_hss | w_long_start) begin
        r_state    <= S_HDR;
        r_tx_valid <= 1'b1;
        r_tx_sop   <= 1'b1;
        r_tx_data  <= w_di;
        r_hdr_sh   <= {w_ecc, w_wc[15:8], w_wc[7:0]};
        r_idx      <= 2'd0;
        r_long     <= w_long_start;
        r_crc      <= 16'hFFFF;
        r_phase    <= 2'd0;
        r_pix_cnt  <= 15'd0;
      end
    end else if ((r_state == S_HDR) && w_slot && (r_idx != 2'd3)) begin
      r_tx_sop  <= 1'b0;
      r_tx_data <= r_hdr_sh[7:0];
      r_hdr_sh  <= {8'h00, r_hdr_sh[23:8]};
      r_idx     <= r_idx + 2'd1;
      r_tx_eop  <= (r_idx == 2'd2) & ~r_long;
    end else if (w_pay_load) begin
      r_state  <= S_PAYLOAD;
      r_tx_sop <= 1'b0;
      r_tx_eop <= 1'b0;
      if (r_phase == 2'd0) begin
        if (r_pix_cnt == C_NPIX) begin
          r_state    <= S_CRC;
          r_tx_valid <= 1'b1;
          r_tx_data  <= r_crc[7:0];
          r_long     <= 1'b0;
        end else if (r_pix_full) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= r_pix[23:16];
          r_gb       <= r_pix[15:0];
          r_crc      <= f_crc(r_crc, r_pix[23:16]);
          r_phase    <= 2'd1;
          r_pix_cnt  <= r_pix_cnt + 15'd1;
        end else begin
          // Pixel not yet available: bubble rather than stall the header
          r_tx_valid <= 1'b0;
        end
      end else begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= r_gb[15:8];
        r_gb       <= {r_gb[7:0], 8'h00};
        r_crc      <= f_crc(r_crc, r_gb[15:8]);
        r_phase    <= (r_phase == 2'd2) ? 2'd0 : (r_phase + 2'd1);
      end
    end else if ((r_state == S_CRC) && w_slot) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= r_crc[15:8];
      r_tx_eop   <= 1'b1;
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_sop    = r_tx_sop;
  assign tx_eop    = r_tx_eop;
  assign pix_ready = r_pix_ready;
  assign sync_drop = r_sync_drop;

endmodule
`default_nettype wire

// File: tb/tb_dsi_video_packetizer.sv
`default_nettype none
//==============================================================================
// Module   : tb_dsi_video_packetizer
// Desc     : Scoreboard bench for dsi_video_packetizer (H_ACTIVE = 2).
// Revision : 1.0 - initial release
//==============================================================================
module tb_dsi_video_packetizer;

  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hsync = 1'b0, vsync = 1'b0;
  logic [7:0] r = 8'h0, g = 8'h0, b = 8'h0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       tx_sop, tx_eop, sync_drop;

  dsi_video_packetizer #(.H_ACTIVE(H)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .sync_drop(sync_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } tx_byte_t;

  tx_byte_t    exp_q[$];
  logic [23:0] pix_q[$];
  int n_tests = 0, n_fail = 0;
  int ready_mode = 0;           // 0: always ready, 1: random, 2: held low
  int n_acc = 0, n_drop = 0;
  int cyc = 0, sop_cyc = 0, eop_cyc = 0, last_len = 0, last_gap = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ECC: XOR of the Hamming column code of every set header bit
  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    logic [5:0] cols [0:23];
    logic [5:0] e;
    cols = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
             6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
             6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    e = 6'h00;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ cols[i];
    return {2'b00, e};
  endfunction

  // Reference CRC: bit-serial, LSB first, reflected poly 0x8408
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      if (x[0] ^ d[i]) x = (x >> 1) ^ 16'h8408;
      else             x = x >> 1;
    end
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic s, input logic e);
    tx_byte_t t;
    t.data = d; t.sop = s; t.eop = e;
    exp_q.push_back(t);
  endtask

  task automatic push_short(input logic [5:0] dt);
    logic [7:0] di;
    di = {2'b00, dt};
    push_byte(di, 1'b1, 1'b0);
    push_byte(8'h00, 1'b0, 1'b0);
    push_byte(8'h00, 1'b0, 1'b0);
    push_byte(ecc_model({16'h0000, di}), 1'b0, 1'b1);
  endtask

  task automatic push_long(input logic [23:0] p0, input logic [23:0] p1);
    logic [23:0] px [0:1];
    logic [15:0] wc, crc;
    logic [7:0]  bt;
    px[0] = p0; px[1] = p1;
    wc  = 16'(3 * H);
    crc = 16'hFFFF;
    push_byte(8'h3E, 1'b1, 1'b0);
    push_byte(wc[7:0], 1'b0, 1'b0);
    push_byte(wc[15:8], 1'b0, 1'b0);
    push_byte(ecc_model({wc, 8'h3E}), 1'b0, 1'b0);
    for (int i = 0; i < H; i++) begin
      for (int k = 2; k >= 0; k--) begin
        bt = px[i][8*k +: 8];
        push_byte(bt, 1'b0, 1'b0);
        crc = crc_step(crc, bt);
      end
    end
    push_byte(crc[7:0], 1'b0, 1'b0);
    push_byte(crc[15:8], 1'b0, 1'b1);
    pix_q.push_back(p0);
    pix_q.push_back(p1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // tx_ready driver
  initial begin
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Pixel source: presents the head of pix_q, pops it after a handshake
  initial begin
    logic hs;
    forever begin
      @(negedge clk);
      hs = pix_valid && pix_ready && reset;
      @(posedge clk); #2;
      if (hs && pix_q.size() > 0) void'(pix_q.pop_front());
      pix_valid = (pix_q.size() > 0);
      if (pix_q.size() > 0) {r, g, b} = pix_q[0];
      else                  {r, g, b} = 24'h0;
    end
  end

  // Output monitor: scoreboard compare, stall stability, packet timing
  initial begin
    tx_byte_t   e;
    logic       held;
    logic [9:0] h_val;
    held = 1'b0;
    h_val = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (sync_drop) n_drop++;
        if (held) begin
          check_eq("stall_valid", 32'(tx_valid), 32'd1);
          check_eq("stall_hold", 32'({tx_data, tx_sop, tx_eop}), 32'(h_val));
        end
        held  = tx_valid && !tx_ready;
        h_val = {tx_data, tx_sop, tx_eop};
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_eq("byte", 32'(tx_data), 32'(e.data));
            check_eq("sop", 32'(tx_sop), 32'(e.sop));
            check_eq("eop", 32'(tx_eop), 32'(e.eop));
          end
          n_acc++;
          if (tx_sop) begin
            sop_cyc  = cyc;
            last_gap = cyc - eop_cyc;
          end
          if (tx_eop) begin
            eop_cyc  = cyc;
            last_len = cyc - sop_cyc + 1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base, n;

    // Reset held low for 3 cycles: all outputs cleared
    tick(3);
    check_eq("reset_outs",
             32'({tx_data, tx_valid, tx_sop, tx_eop, pix_ready, sync_drop}), 32'd0);
    reset = 1'b1;
    tick(3);
    check_eq("idle_valid", 32'(tx_valid), 32'd0);

    // VSS short packet and its start latency
    n_acc = 0;
    push_short(6'h01);
    vsync = 1'b1;
    tick(2);
    check_eq("vss_lat_early", 32'(tx_valid), 32'd0);
    tick(1);
    check_eq("vss_lat_valid", 32'(tx_valid), 32'd1);
    check_eq("vss_lat_di", 32'(tx_data), 32'h01);
    tick(2);
    vsync = 1'b0;
    wait_drain("vss_drain", 100);
    tick(5);
    check_eq("vss_count", 32'(n_acc), 32'd4);
    check_eq("vss_len", 32'(last_len), 32'd4);

    // HSS short packet
    push_short(6'h21);
    hsync = 1'b1;
    tick(2);
    hsync = 1'b0;
    wait_drain("hss_drain", 100);
    tick(4);

    // Long packet with the two reference pixels, full throughput
    push_long(24'hFF0000, 24'h00FF00);
    wait_drain("long_drain", 200);
    check_eq("long_len", 32'(last_len), 32'(4 + 3 * H + 2));
    tick(4);

    // Simultaneous vsync/hsync: VSS then HSS back-to-back, no drop
    n_drop = 0;
    push_short(6'h01);
    push_short(6'h21);
    vsync = 1'b1; hsync = 1'b1;
    tick(2);
    vsync = 1'b0; hsync = 1'b0;
    wait_drain("both_drain", 100);
    check_eq("both_gap", 32'(last_gap), 32'd1);
    tick(3);
    check_eq("both_drop", 32'(n_drop), 32'd0);

    // Two hsync pulses during a stalled long packet: one HSS, one drop
    n_drop = 0;
    ready_mode = 2;
    push_long(24'h123456, 24'hA5C3E1);
    push_short(6'h21);
    tick(3);
    hsync = 1'b1; tick(2); hsync = 1'b0; tick(2);
    hsync = 1'b1; tick(2); hsync = 1'b0; tick(2);
    ready_mode = 0;
    wait_drain("merge_drain", 200);
    check_eq("merge_gap", 32'(last_gap), 32'd1);
    tick(4);
    check_eq("merge_drop", 32'(n_drop), 32'd1);

    // Random backpressure over several back-to-back long packets
    ready_mode = 1;
    for (int i = 0; i < 4; i++) push_long(24'($urandom), 24'($urandom));
    wait_drain("rand_drain", 2000);
    tick(5);

    // Reset asserted in the middle of a long packet's payload
    base = n_acc;
    push_long(24'hDEADBE, 24'h0BCAFE);
    n = 0;
    while (n_acc < base + 5 && n < 500) begin
      tick(1);
      n++;
    end
    check_eq("mid_reach", 32'(n_acc >= base + 5), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_reset_outs",
             32'({tx_data, tx_valid, tx_sop, tx_eop, pix_ready, sync_drop}), 32'd0);
    exp_q.delete();
    pix_q.delete();
    tick(2);
    reset = 1'b1;
    tick(3);
    check_eq("post_reset_idle", 32'(tx_valid), 32'd0);

    // Clean restart after the abort
    push_short(6'h01);
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    wait_drain("restart_vss", 200);
    push_long(24'h010203, 24'hFEFDFC);
    wait_drain("restart_long", 500);
    ready_mode = 0;
    tick(10);
    check_eq("final_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
